// File: rtl/psr_ctrl.sv
// Sequencer for the pipeline stage register chain: alternates load-left / shift-right strobes
// and handles hazard stalls, taken-branch flushes and Ri reloads. All outputs are registered.
module psr_ctrl #(
   parameter int unsigned NSTAGE    = 4,
   parameter int unsigned BR_STAGE  = 2,
   parameter int unsigned STALL_MAX = 15
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   input  logic              hazard,
   input  logic              branch_taken,
   input  logic              multi,
   output logic [NSTAGE-1:0] c_left,
   output logic [NSTAGE-1:0] c_right,
   output logic              ld_ri,
   output logic [NSTAGE-1:0] flush_n,
   output logic [3:0]        stall_cnt,
   output logic              stall_err,
   output logic              busy
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StStall,
      StRi,
      StFlush
   } state_e;

   localparam logic [3:0] StallMax = 4'(STALL_MAX);

   // Stages upstream of the branch-resolving stage are cleared on a flush.
   function automatic logic [NSTAGE-1:0] flush_mask();
      logic [NSTAGE-1:0] m;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
         m[i] = (i >= BR_STAGE);
      end
      return m;
   endfunction

   localparam logic [NSTAGE-1:0] FlushMask = flush_mask();

   state_e            state_q, state_d;
   logic [3:0]        stall_cnt_q, stall_cnt_d;
   logic              stall_err_q, stall_err_d;
   logic [NSTAGE-1:0] c_left_q, c_left_d;
   logic [NSTAGE-1:0] c_right_q, c_right_d;
   logic [NSTAGE-1:0] flush_n_q, flush_n_d;
   logic              ld_ri_q, ld_ri_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      stall_err_d = stall_err_q;
      unique case (state_q)
         StIdle: begin
            if (run) state_d = StLoad;
         end
         StLoad: begin
            state_d = StShift;
         end
         StShift: begin
            if (branch_taken) begin
               state_d = StFlush;
            end else if (!run) begin
               state_d = StIdle;
            end else if (hazard) begin
               state_d     = StStall;
               stall_cnt_d = 4'd1;
            end else if (multi) begin
               state_d = StRi;
            end else begin
               state_d = StLoad;
            end
         end
         StStall: begin
            if (!hazard) begin
               state_d     = StLoad;
               stall_cnt_d = 4'd0;
            end else if (stall_cnt_q >= StallMax) begin
               state_d     = StFlush;
               stall_err_d = 1'b1;
               stall_cnt_d = 4'd0;
            end else begin
               stall_cnt_d = (stall_cnt_q == 4'hF) ? 4'hF : stall_cnt_q + 4'd1;
            end
         end
         StRi: begin
            state_d = StShift;
         end
         StFlush: begin
            state_d = run ? StLoad : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are decoded from the state being entered so they line up with state_q.
   always_comb begin
      c_left_d  = '0;
      c_right_d = '0;
      ld_ri_d   = 1'b0;
      flush_n_d = '1;
      busy_d    = (state_d != StIdle);
      unique case (state_d)
         StLoad:  c_left_d  = '1;
         StShift: c_right_d = '1;
         StRi:    ld_ri_d   = 1'b1;
         StFlush: flush_n_d = FlushMask;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= StIdle;
         stall_cnt_q <= 4'd0;
         stall_err_q <= 1'b0;
         c_left_q    <= '0;
         c_right_q   <= '0;
         ld_ri_q     <= 1'b0;
         flush_n_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
         c_left_q    <= c_left_d;
         c_right_q   <= c_right_d;
         ld_ri_q     <= ld_ri_d;
         flush_n_q   <= flush_n_d;
         busy_q      <= busy_d;
      end
   end

   assign c_left    = c_left_q;
   assign c_right   = c_right_q;
   assign ld_ri     = ld_ri_q;
   assign flush_n   = flush_n_q;
   assign stall_cnt = stall_cnt_q;
   assign stall_err = stall_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_psr_ctrl.sv
// Bench for psr_ctrl: two instances (STALL_MAX 15 and 3) share stimulus and are checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_psr_ctrl;

   localparam int P_IDLE  = 0;
   localparam int P_LOAD  = 1;
   localparam int P_SHIFT = 2;
   localparam int P_STALL = 3;
   localparam int P_RI    = 4;
   localparam int P_FLUSH = 5;

   logic clk = 1'b0;
   logic clr, run, hazard, branch_taken, multi;

   logic [3:0] cl0, cr0, fn0, sc0, cl1, cr1, fn1, sc1;
   logic       lr0, se0, bz0, lr1, se1, bz1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   psr_ctrl #(.NSTAGE(4), .BR_STAGE(2), .STALL_MAX(15)) dut (
      .clk(clk), .clr(clr), .run(run), .hazard(hazard), .branch_taken(branch_taken),
      .multi(multi), .c_left(cl0), .c_right(cr0), .ld_ri(lr0), .flush_n(fn0),
      .stall_cnt(sc0), .stall_err(se0), .busy(bz0)
   );

   psr_ctrl #(.NSTAGE(4), .BR_STAGE(2), .STALL_MAX(3)) dut3 (
      .clk(clk), .clr(clr), .run(run), .hazard(hazard), .branch_taken(branch_taken),
      .multi(multi), .c_left(cl1), .c_right(cr1), .ld_ri(lr1), .flush_n(fn1),
      .stall_cnt(sc1), .stall_err(se1), .busy(bz1)
   );

   // Model: pipeline phase, stall count, sticky error, and "outputs still at reset value".
   int   ph   [2];
   int   cnt  [2];
   bit   err  [2];
   bit   rfl  [2];
   int   smax [2] = '{15, 3};

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int k = 0; k < 2; k++) begin
            ph[k] = P_IDLE; cnt[k] = 0; err[k] = 1'b0; rfl[k] = 1'b1;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            rfl[k] = 1'b0;
            case (ph[k])
               P_IDLE:  if (run) ph[k] = P_LOAD;
               P_LOAD:  ph[k] = P_SHIFT;
               P_SHIFT: begin
                  if (branch_taken)  ph[k] = P_FLUSH;
                  else if (!run)     ph[k] = P_IDLE;
                  else if (hazard) begin ph[k] = P_STALL; cnt[k] = 1; end
                  else if (multi)    ph[k] = P_RI;
                  else               ph[k] = P_LOAD;
               end
               P_STALL: begin
                  if (!hazard) begin ph[k] = P_LOAD; cnt[k] = 0; end
                  else if (cnt[k] == smax[k]) begin
                     ph[k] = P_FLUSH; err[k] = 1'b1; cnt[k] = 0;
                  end else cnt[k] = (cnt[k] < 15) ? cnt[k] + 1 : 15;
               end
               P_RI:    ph[k] = P_SHIFT;
               default: ph[k] = run ? P_LOAD : P_IDLE;
            endcase
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [3:0] acl, acr, afn, asc;
         logic       alr, ase, abz;
         logic [3:0] ecl, ecr, efn;
         string      s;
         acl = (k == 0) ? cl0 : cl1;  acr = (k == 0) ? cr0 : cr1;
         afn = (k == 0) ? fn0 : fn1;  asc = (k == 0) ? sc0 : sc1;
         alr = (k == 0) ? lr0 : lr1;  ase = (k == 0) ? se0 : se1;
         abz = (k == 0) ? bz0 : bz1;
         ecl = (!rfl[k] && ph[k] == P_LOAD)  ? 4'hF : 4'h0;
         ecr = (!rfl[k] && ph[k] == P_SHIFT) ? 4'hF : 4'h0;
         efn = rfl[k] ? 4'h0 : (ph[k] == P_FLUSH) ? 4'b1100 : 4'hF;
         s = $sformatf("u%0d", k);
         check({s, ".c_left"},    32'(acl), 32'(ecl));
         check({s, ".c_right"},   32'(acr), 32'(ecr));
         check({s, ".flush_n"},   32'(afn), 32'(efn));
         check({s, ".ld_ri"},     32'(alr), 32'(!rfl[k] && ph[k] == P_RI));
         check({s, ".stall_cnt"}, 32'(asc), 32'(cnt[k]));
         check({s, ".stall_err"}, 32'(ase), 32'(err[k]));
         check({s, ".busy"},      32'(abz), 32'(!rfl[k] && ph[k] != P_IDLE));
         check({s, ".lr_excl"},   32'((acl != 0) && (acr != 0)), 32'(0));
         check({s, ".ri_excl"},   32'(alr && acl[0]), 32'(0));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b0; run = 1'b0; hazard = 1'b0; branch_taken = 1'b0; multi = 1'b0;
      #1;
      check("rst.flush_n", 32'(fn0), 32'h0);
      check("rst.busy", 32'(bz0), 32'h0);
      step(); step();
      check("rst.hold_flush_n", 32'(fn0), 32'h0);
      clr = 1'b1; run = 1'b1;
      step();
      check("run.first_load", 32'(cl0), 32'hF);
      check("run.flush_n", 32'(fn0), 32'hF);
      check("run.busy", 32'(bz0), 32'h1);
      step();
      check("run.shift", 32'(cr0), 32'hF);
      step(); step();
      // Three-cycle hazard from SHIFT
      hazard = 1'b1;
      step(); check("hz.cnt1", 32'(sc0), 32'd1);
      step(); check("hz.cnt2", 32'(sc0), 32'd2);
      step(); check("hz.cnt3", 32'(sc0), 32'd3);
      check("hz.no_strobe", 32'({cl0, cr0}), 32'h0);
      hazard = 1'b0;
      step();
      check("hz.load", 32'(cl0), 32'hF);
      check("hz.cnt0", 32'(sc0), 32'd0);
      check("hz3.load", 32'(cl1), 32'hF);
      check("hz3.err0", 32'(se1), 32'd0);
      step();
      // Taken branch from SHIFT
      branch_taken = 1'b1;
      step();
      check("br.flush_n", 32'(fn0), 32'b1100);
      check("br.c_left", 32'(cl0), 32'h0);
      branch_taken = 1'b0;
      step(); check("br.load", 32'(cl0), 32'hF);
      step();
      // Ri reload from SHIFT
      multi = 1'b1;
      step();
      check("ri.ld_ri", 32'(lr0), 32'h1);
      check("ri.c_left", 32'(cl0), 32'h0);
      multi = 1'b0;
      step(); check("ri.shift", 32'(cr0), 32'hF);
      step(); check("ri.load", 32'(cl0), 32'hF);
      step();
      // Held hazard: STALL_MAX=3 instance flushes after count 3
      hazard = 1'b1;
      step(); step(); step();
      check("smax3.cnt3", 32'(sc1), 32'd3);
      step();
      check("smax3.flush_n", 32'(fn1), 32'b1100);
      check("smax3.err", 32'(se1), 32'd1);
      check("smax15.cnt4", 32'(sc0), 32'd4);
      hazard = 1'b0;
      step(); check("smax3.err_sticky", 32'(se1), 32'd1);
      step();
      // Held hazard: default instance flushes after count 15
      hazard = 1'b1;
      repeat (15) step();
      check("smax15.cnt15", 32'(sc0), 32'd15);
      step();
      check("smax15.flush_n", 32'(fn0), 32'b1100);
      check("smax15.err", 32'(se0), 32'd1);
      check("smax15.cnt0", 32'(sc0), 32'd0);
      hazard = 1'b0;
      // run=0 from SHIFT returns to IDLE
      step(); step();
      run = 1'b0;
      step();
      check("stop.busy", 32'(bz0), 32'd0);
      check("stop.flush_n", 32'(fn0), 32'hF);
      // Asynchronous reset mid-LOAD
      run = 1'b1;
      step();
      check("arst.pre_load", 32'(cl0), 32'hF);
      #1 clr = 1'b0;
      #1;
      check("arst.c_left", 32'(cl0), 32'h0);
      check("arst.flush_n", 32'(fn0), 32'h0);
      check("arst.err_clr", 32'(se1), 32'd0);
      run = 1'b0;
      step();
      clr = 1'b1;
      step();
      check("rel.flush_n", 32'(fn0), 32'hF);
      check("rel.busy", 32'(bz0), 32'd0);
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
